operand_fetch_stage: RTL

Read-side companion of the flip-flop integer register file.
- Accepts decoded instructions over a valid/ready handshake.
- Drives the register file read addresses and tracks pending destination registers in a per-register scoreboard.
- Forwards same-cycle writeback data and stalls on hazards.
- Presents registered operands to the execute stage over a second valid/ready handshake.

---
 rtl/operand_fetch_stage_pkg.sv | 23 ++
 rtl/operand_fetch_stage_bypass.sv | 33 +++
 rtl/operand_fetch_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage: register addressing and the
// registered operand bundle handed to execute.
package operand_fetch_stage_pkg;

  localparam int unsigned REG_ADDR_BITS  = 5;
  localparam int unsigned NUM_REGS       = 32;
  // Operand fields in the bundle are sized for the widest supported datapath.
  localparam int unsigned OPF_MAX_DATA_W = 64;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

  typedef struct packed {
    logic [OPF_MAX_DATA_W-1:0] a;
    logic [OPF_MAX_DATA_W-1:0] b;
    reg_addr_t                 rd;
    logic                      rd_we;
  } op_bundle_t;

  function automatic logic is_zero_reg(input reg_addr_t r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_bypass.sv
// Per-operand writeback forwarding: the highest-index matching writeback port
// wins, mirroring the register file's last-port-wins write order.
module operand_bypass_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic [REG_ADDR_BITS-1:0]                  rs_i,
  input  logic [DATA_WIDTH-1:0]                     rf_rdata_i,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][REG_ADDR_BITS-1:0] wb_addr_i,
  input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]    wb_data_i,
  output logic                                      fwd_o,
  output logic [DATA_WIDTH-1:0]                     data_o
);

  always_comb begin
    fwd_o  = 1'b0;
    data_o = rf_rdata_i;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && (wb_addr_i[k] == rs_i)) begin
        fwd_o  = 1'b1;
        data_o = wb_data_i[k];
      end
    end
    if (ZERO_REG_ZERO && is_zero_reg(rs_i)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, forwards writeback data, tracks
// pending destinations and stalls on RAW/WAW hazards ahead of execute.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic                                      req_valid_i,
  output logic                                      req_ready_o,
  input  logic [REG_ADDR_BITS-1:0]                  req_rs1_i,
  input  logic [REG_ADDR_BITS-1:0]                  req_rs2_i,
  input  logic [REG_ADDR_BITS-1:0]                  req_rd_i,
  input  logic                                      req_rd_we_i,
  output logic [1:0][REG_ADDR_BITS-1:0]             rf_raddr_o,
  input  logic [1:0][DATA_WIDTH-1:0]                rf_rdata_i,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][REG_ADDR_BITS-1:0] wb_addr_i,
  input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]    wb_data_i,
  output logic                                      op_valid_o,
  input  logic                                      op_ready_i,
  output logic [DATA_WIDTH-1:0]                     op_a_o,
  output logic [DATA_WIDTH-1:0]                     op_b_o,
  output logic [REG_ADDR_BITS-1:0]                  op_rd_o,
  output logic                                      op_rd_we_o
);

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  op_bundle_t            op_q, op_d;
  logic                  op_valid_q, op_valid_d;

  logic                  fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;
  logic                  raw_a, raw_b, waw, wb_hits_rd, accept;

  assign rf_raddr_o = {req_rs2_i, req_rs1_i};

  operand_bypass_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NR_WB_PORTS   (NR_WB_PORTS),
    .ZERO_REG_ZERO (ZERO_REG_ZERO)
  ) u_bypass_a (
    .rs_i       (req_rs1_i),
    .rf_rdata_i (rf_rdata_i[0]),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .fwd_o      (fwd_a),
    .data_o     (opnd_a)
  );

  operand_bypass_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NR_WB_PORTS   (NR_WB_PORTS),
    .ZERO_REG_ZERO (ZERO_REG_ZERO)
  ) u_bypass_b (
    .rs_i       (req_rs2_i),
    .rf_rdata_i (rf_rdata_i[1]),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .fwd_o      (fwd_b),
    .data_o     (opnd_b)
  );

  always_comb begin
    wb_hits_rd = 1'b0;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && (wb_addr_i[k] == req_rd_i)) begin
        wb_hits_rd = 1'b1;
      end
    end
  end

  // A writeback landing this cycle resolves the hazard on its register.
  assign raw_a = pending_q[req_rs1_i] && !fwd_a && !is_zero_reg(req_rs1_i);
  assign raw_b = pending_q[req_rs2_i] && !fwd_b && !is_zero_reg(req_rs2_i);
  assign waw   = req_rd_we_i && pending_q[req_rd_i] && !is_zero_reg(req_rd_i) && !wb_hits_rd;

  assign req_ready_o = rst_ni && !flush_i && (!op_valid_q || op_ready_i)
                       && !raw_a && !raw_b && !waw;
  assign accept      = req_valid_i && req_ready_o;

  // Clears are applied before the set so a younger owner keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k]) begin
        pending_d[wb_addr_i[k]] = 1'b0;
      end
    end
    if (accept && req_rd_we_i && !is_zero_reg(req_rd_i)) begin
      pending_d[req_rd_i] = 1'b1;
    end
    if (flush_i) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    op_d       = op_q;
    op_valid_d = op_valid_q;
    if (flush_i) begin
      op_valid_d = 1'b0;
    end else if (accept) begin
      op_d.a     = OPF_MAX_DATA_W'(opnd_a);
      op_d.b     = OPF_MAX_DATA_W'(opnd_b);
      op_d.rd    = req_rd_i;
      op_d.rd_we = req_rd_we_i;
      op_valid_d = 1'b1;
    end else if (op_valid_q && op_ready_i) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign op_valid_o = op_valid_q;
  assign op_a_o     = op_q.a[DATA_WIDTH-1:0];
  assign op_b_o     = op_q.b[DATA_WIDTH-1:0];
  assign op_rd_o    = op_q.rd;
  assign op_rd_we_o = op_q.rd_we;

endmodule
